button_debounce: RTL and testbench

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

---
 rtl/button_debounce.sv | 172 +++++++++++++++++
 tb/tb_button_debounce.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// button_debounce
// Takes a raw, bouncy GPIO button and produces a clean pressed level, one-cycle
// press, release and long-press strobes, and a running count of presses.
//
// Ports
//   clk_in        in   1  system clock, every register updates on its rising edge
//   reset         in   1  synchronous active-high reset
//   btn_pin       in   1  raw asynchronous button pin (polarity set by ACTIVE_LOW)
//   btn_level     out  1  debounced state, 1 = pressed
//   press_pulse   out  1  one-cycle strobe when a press is accepted
//   release_pulse out  1  one-cycle strobe when a release is accepted
//   long_pulse    out  1  one-cycle strobe when a hold lasts LONG_CYCLES
//   press_count   out  8  number of accepted presses, wraps modulo 256
//
// state        | meaning
// RELEASED     | debounced level is released, waiting for an active sample
// WAIT_PRESS   | candidate press, counting consecutive active samples
// PRESSED      | debounced level is pressed, hold timer running
// WAIT_RELEASE | candidate release, counting consecutive inactive samples

module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned LONG_CYCLES     = 100000000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       btn_pin,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        WAIT_PRESS   = 2'd1,
        PRESSED      = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_t;

    localparam logic [31:0] DEB_LAST  = 32'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] HOLD_LAST = 32'(LONG_CYCLES - 1);

    logic        sync_1;
    logic        sync_2;
    logic        btn_sync;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] deb_cnt;
    logic [31:0] deb_nxt;
    logic [31:0] hold_cnt;
    logic [31:0] hold_nxt;
    logic [31:0] hold_step;
    logic        long_done;
    logic        long_done_nxt;
    logic        level_nxt;
    logic        press_nxt;
    logic        release_nxt;
    logic        long_nxt;
    logic [7:0]  count_nxt;

    // Two-flop synchronizer; reset parks both stages at the idle pin level so
    // leaving reset never looks like an edge.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            sync_1 <= ACTIVE_LOW;
            sync_2 <= ACTIVE_LOW;
        end else begin
            sync_1 <= btn_pin;
            sync_2 <= sync_1;
        end
    end

    assign btn_sync = sync_2 ^ ACTIVE_LOW;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state         <= RELEASED;
            deb_cnt       <= '0;
            hold_cnt      <= '0;
            long_done     <= 1'b0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            press_count   <= '0;
        end else begin
            state         <= state_nxt;
            deb_cnt       <= deb_nxt;
            hold_cnt      <= hold_nxt;
            long_done     <= long_done_nxt;
            btn_level     <= level_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
            long_pulse    <= long_nxt;
            press_count   <= count_nxt;
        end
    end

    // Saturating hold timer step; it never wraps, so a very long hold cannot
    // produce a second long_pulse.
    assign hold_step = (hold_cnt < HOLD_LAST) ? hold_cnt + 32'd1 : hold_cnt;

    always_comb begin
        state_nxt     = state;
        deb_nxt       = deb_cnt;
        hold_nxt      = hold_cnt;
        long_done_nxt = long_done;
        level_nxt     = btn_level;
        press_nxt     = 1'b0;
        release_nxt   = 1'b0;
        long_nxt      = 1'b0;
        count_nxt     = press_count;

        // Hold timing keeps running through release bounce (WAIT_RELEASE), and
        // a long press may land on the same edge as the accepted release.
        if (state == PRESSED || state == WAIT_RELEASE) begin
            hold_nxt = hold_step;
            if (hold_step == HOLD_LAST && !long_done) begin
                long_nxt      = 1'b1;
                long_done_nxt = 1'b1;
            end
        end

        case (state)
            RELEASED: begin
                if (btn_sync) begin
                    state_nxt = WAIT_PRESS;
                    deb_nxt   = '0;
                end
            end
            WAIT_PRESS: begin
                if (!btn_sync) begin
                    state_nxt = RELEASED;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nxt     = PRESSED;
                    level_nxt     = 1'b1;
                    press_nxt     = 1'b1;
                    count_nxt     = press_count + 8'd1;
                    hold_nxt      = '0;
                    long_done_nxt = 1'b0;
                end else begin
                    deb_nxt = deb_cnt + 32'd1;
                end
            end
            PRESSED: begin
                if (!btn_sync) begin
                    state_nxt = WAIT_RELEASE;
                    deb_nxt   = '0;
                end
            end
            WAIT_RELEASE: begin
                if (btn_sync) begin
                    state_nxt = PRESSED;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nxt   = RELEASED;
                    level_nxt   = 1'b0;
                    release_nxt = 1'b1;
                end else begin
                    deb_nxt = deb_cnt + 32'd1;
                end
            end
            default: begin
                state_nxt = RELEASED;
            end
        endcase
    end

endmodule

// File: tb/tb_button_debounce.sv
// Randomized and directed bench for button_debounce (D=4, LONG=20, active-low pin).
// The reference model treats the debouncer as "accept a new level after D+1
// consecutive synchronized samples that disagree with the current level" and
// the long press as "the hold has lasted LONG-1 edges since acceptance".

module tb_button_debounce;

    localparam int unsigned D = 4;
    localparam int unsigned L = 20;

    logic       clk_in  = 1'b0;
    logic       reset   = 1'b1;
    logic       btn_pin = 1'b1;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_pulse;
    logic [7:0] press_count;

    always #5 clk_in = ~clk_in;

    button_debounce #(
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk_in        (clk_in),
        .reset         (reset),
        .btn_pin       (btn_pin),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .press_count   (press_count)
    );

    // reference model state
    bit       pipe [2];      // pin delay through the synchronizer, 1 = pressed
    bit       m_level;
    int       run;           // consecutive samples disagreeing with m_level
    int       held;          // edges spent pressed since acceptance
    bit       e_press, e_rel, e_long;
    bit [7:0] m_count;

    int n_vec = 0;
    int n_err = 0;
    int edge_no = 0;
    int n_press = 0, n_rel = 0, n_long = 0;
    int t_press, t_long, t_rel;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit pin, input bit rst);
        bit bs;
        e_press = 1'b0;
        e_rel   = 1'b0;
        e_long  = 1'b0;
        if (rst) begin
            pipe[0] = 1'b0;
            pipe[1] = 1'b0;
            m_level = 1'b0;
            run     = 0;
            held    = 0;
            m_count = '0;
        end else begin
            bs      = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = ~pin;
            if (m_level) begin
                held++;
                if (held == int'(L) - 1) e_long = 1'b1;
            end
            if (bs != m_level) begin
                run++;
                if (run == int'(D) + 1) begin
                    m_level = bs;
                    run     = 0;
                    if (bs) begin
                        e_press = 1'b1;
                        m_count = m_count + 8'd1;
                        held    = 0;
                    end else begin
                        e_rel = 1'b1;
                    end
                end
            end else begin
                run = 0;
            end
        end
    endtask

    task automatic step(input bit pin, input bit rst);
        btn_pin = pin;
        reset   = rst;
        @(posedge clk_in);
        model_edge(pin, rst);
        #1;
        edge_no++;
        check("btn_level",     32'(btn_level),     32'(m_level));
        check("press_pulse",   32'(press_pulse),   32'(e_press));
        check("release_pulse", 32'(release_pulse), 32'(e_rel));
        check("long_pulse",    32'(long_pulse),    32'(e_long));
        check("press_count",   32'(press_count),   32'(m_count));
        if (press_pulse)   n_press++;
        if (release_pulse) n_rel++;
        if (long_pulse)    n_long++;
    endtask

    initial begin
        int np, nr, nl, len;
        bit pin;

        repeat (3) step(1'b1, 1'b1);
        repeat (3) step(1'b1, 1'b0);

        // clean press, long hold, release
        np = n_press; nl = n_long;
        edge_no = 0; t_press = -1; t_long = -1;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b0);
            if (press_pulse && t_press < 0) t_press = edge_no;
            if (long_pulse && t_long < 0)   t_long  = edge_no;
        end
        check("press_latency", 32'(t_press), 32'd7);
        check("long_delay",    32'(t_long - t_press), 32'd19);
        check("long_count",    32'(n_long - nl), 32'd1);
        check("press_once",    32'(n_press - np), 32'd1);
        edge_no = 0; t_rel = -1;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0);
            if (release_pulse && t_rel < 0) t_rel = edge_no;
        end
        check("release_latency", 32'(t_rel), 32'd7);

        // bounce shorter than the debounce window
        np = n_press;
        repeat (5) begin
            repeat (3) step(1'b0, 1'b0);
            repeat (2) step(1'b1, 1'b0);
        end
        repeat (4) step(1'b1, 1'b0);
        check("bounce_no_press", 32'(n_press - np), 32'd0);
        check("bounce_level",    32'(btn_level), 32'd0);

        // release glitch while pressed
        np = n_press; nr = n_rel; nl = n_long;
        edge_no = 0; t_press = -1; t_long = -1;
        for (int i = 0; i < 40; i++) begin
            step((i >= 12 && i < 14) ? 1'b1 : 1'b0, 1'b0);
            if (press_pulse && t_press < 0) t_press = edge_no;
            if (long_pulse && t_long < 0)   t_long  = edge_no;
        end
        check("glitch_no_release", 32'(n_rel - nr), 32'd0);
        check("glitch_one_press",  32'(n_press - np), 32'd1);
        check("glitch_long_delay", 32'(t_long - t_press), 32'd19);
        check("glitch_long_count", 32'(n_long - nl), 32'd1);
        repeat (10) step(1'b1, 1'b0);

        // reset on the third WAIT_PRESS cycle with the pin held pressed
        repeat (5) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        edge_no = 0; t_press = -1;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0);
            if (press_pulse && t_press < 0) t_press = edge_no;
        end
        check("reset_press_latency", 32'(t_press), 32'd7);
        repeat (10) step(1'b1, 1'b0);

        // press_count wrap
        step(1'b1, 1'b1);
        repeat (2) step(1'b1, 1'b0);
        np = n_press;
        repeat (256) begin
            repeat (9) step(1'b0, 1'b0);
            repeat (9) step(1'b1, 1'b0);
        end
        check("wrap_presses", 32'(n_press - np), 32'd256);
        check("wrap_count",   32'(press_count), 32'd0);

        // random pin activity with occasional resets
        for (int s = 0; s < 400; s++) begin
            pin = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(15, 30))
                                              : int'($urandom_range(1, 8));
            if ($urandom_range(0, 40) == 0) begin
                repeat ($urandom_range(1, 2)) step(pin, 1'b1);
            end
            repeat (len) step(pin, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
